// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node initiator side: routing-FIFO entry layout and W-router FSM states.
// Sizes here set the default geometry of axi_dw_router.
package axi_node_pkg;

    localparam int unsigned NODE_N_INIT_PORT = 8;
    localparam int unsigned NODE_LOG_N_INIT  = $clog2(NODE_N_INIT_PORT);

    typedef struct packed {
        logic                        err;
        logic [NODE_LOG_N_INIT-1:0]  bin;
        logic [NODE_N_INIT_PORT-1:0] oh;
    } route_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } dw_state_t;

    function automatic route_t route_pack(input logic err, input logic [NODE_LOG_N_INIT-1:0] bin);
        route_t r;
        r.err = err;
        r.bin = bin;
        r.oh  = err ? '0 : (NODE_N_INIT_PORT'(1) << bin);
        return r;
    endfunction

endpackage

// File: rtl/fifo_v2.sv
// Generic synchronous FIFO with optional fall-through; DEPTH must be a power of two.
// Latency 1 cycle push-to-pop (0 with FALL_THROUGH); pushes while full and pops while empty are ignored.
module fifo_v2 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  store_empty;
    logic                  bypass;
    logic                  do_push;
    logic                  do_pop;
    logic                  write_mem;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign store_empty = (cnt_q == '0);
    assign full_o      = (cnt_q == DEPTH_C);
    assign bypass      = FALL_THROUGH && store_empty && push_i;
    assign empty_o     = store_empty & ~bypass;
    assign data_o      = bypass ? data_i : mem_q[rd_ptr_q];
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    // A fall-through word consumed in the same cycle never touches storage.
    assign write_mem   = do_push & ~flush_i & ~(bypass & do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (!(bypass && do_pop)) begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_mem) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_dw_router.sv
// Steers slave-side W bursts to one of N master W ports in AW-grant order; decode-error bursts are drained.
// Zero-latency combinational W path; beats stall (wready_o=0) until their route is at the FIFO head.
module axi_dw_router
    import axi_node_pkg::*;
#(
    parameter int unsigned AXI_USER_W   = 6,
    parameter int unsigned N_INIT_PORT  = NODE_N_INIT_PORT,
    parameter int unsigned LOG_N_INIT   = $clog2(N_INIT_PORT),
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned AXI_DATA_W   = 64,
    parameter int unsigned AXI_NUMBYTES = AXI_DATA_W/8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    test_en_i,

    input  logic [AXI_DATA_W-1:0]                   wdata_i,
    input  logic [AXI_NUMBYTES-1:0]                 wstrb_i,
    input  logic                                    wlast_i,
    input  logic [AXI_USER_W-1:0]                   wuser_i,
    input  logic                                    wvalid_i,
    output logic                                    wready_o,

    output logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0]  wdata_o,
    output logic [N_INIT_PORT-1:0][AXI_NUMBYTES-1:0] wstrb_o,
    output logic [N_INIT_PORT-1:0]                  wlast_o,
    output logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]  wuser_o,
    output logic [N_INIT_PORT-1:0]                  wvalid_o,
    input  logic [N_INIT_PORT-1:0]                  wready_i,

    input  logic                                    push_ID_i,
    input  logic [1+LOG_N_INIT+N_INIT_PORT-1:0]     ID_i,
    output logic                                    grant_FIFO_ID_o,

    output logic                                    err_wlast_o
);

    localparam int unsigned ID_W = 1 + LOG_N_INIT + N_INIT_PORT;

    dw_state_t       state_q, state_d;
    logic [ID_W-1:0] fifo_dout;
    route_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            route_err;
    logic            w_hs;
    logic            w_pop;

    fifo_v2 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (ID_W),
        .DEPTH        (FIFO_DEPTH)
    ) u_id_fifo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (1'b0),
        .testmode_i (test_en_i),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .data_i     (ID_i),
        .push_i     (push_ID_i & ~fifo_full),
        .data_o     (fifo_dout),
        .pop_i      (w_pop)
    );

    assign head            = fifo_dout;
    assign grant_FIFO_ID_o = ~fifo_full;

    // Payload is broadcast; only the valid/ready pair carries routing.
    assign wdata_o = {N_INIT_PORT{wdata_i}};
    assign wstrb_o = {N_INIT_PORT{wstrb_i}};
    assign wlast_o = {N_INIT_PORT{wlast_i}};
    assign wuser_o = {N_INIT_PORT{wuser_i}};

    assign w_hs        = wvalid_i & wready_o;
    assign w_pop       = w_hs & wlast_i;
    assign err_wlast_o = w_pop & route_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && w_hs && !wlast_i) state_d = head.err ? DROP : BURST;
            end
            BURST, DROP: begin
                if (w_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wvalid_o  = '0;
        wready_o  = 1'b0;
        route_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    route_err = head.err;
                    if (head.err) begin
                        wready_o = 1'b1;
                    end else begin
                        wvalid_o = head.oh & {N_INIT_PORT{wvalid_i}};
                        wready_o = wready_i[head.bin];
                    end
                end
            end
            BURST: begin
                wvalid_o = head.oh & {N_INIT_PORT{wvalid_i}};
                wready_o = wready_i[head.bin];
            end
            DROP: begin
                route_err = 1'b1;
                wready_o  = 1'b1;
            end
            default: begin
                wvalid_o  = '0;
                wready_o  = 1'b0;
                route_err = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_dw_router.sv
// Directed bench for axi_dw_router: single beat, stalled burst, error drain, back-to-back, FIFO full, W-before-AW, reset.
module tb_axi_dw_router;
    import axi_node_pkg::*;

    localparam int N  = 8;
    localparam int DW = 64;
    localparam int NB = 8;
    localparam int UW = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    test_en_i;
    logic [DW-1:0]           wdata_i;
    logic [NB-1:0]           wstrb_i;
    logic                    wlast_i;
    logic [UW-1:0]           wuser_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [N-1:0][DW-1:0]    wdata_o;
    logic [N-1:0][NB-1:0]    wstrb_o;
    logic [N-1:0]            wlast_o;
    logic [N-1:0][UW-1:0]    wuser_o;
    logic [N-1:0]            wvalid_o;
    logic [N-1:0]            wready_i;
    logic                    push_ID_i;
    logic [11:0]             ID_i;
    logic                    grant_FIFO_ID_o;
    logic                    err_wlast_o;

    int vectors     = 0;
    int miscompares = 0;
    int ports4 [3]  = '{1, 7, 1};

    always #5 clk = ~clk;

    axi_dw_router dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .test_en_i       (test_en_i),
        .wdata_i         (wdata_i),
        .wstrb_i         (wstrb_i),
        .wlast_i         (wlast_i),
        .wuser_i         (wuser_i),
        .wvalid_i        (wvalid_i),
        .wready_o        (wready_o),
        .wdata_o         (wdata_o),
        .wstrb_o         (wstrb_o),
        .wlast_o         (wlast_o),
        .wuser_o         (wuser_o),
        .wvalid_o        (wvalid_o),
        .wready_i        (wready_i),
        .push_ID_i       (push_ID_i),
        .ID_i            (ID_i),
        .grant_FIFO_ID_o (grant_FIFO_ID_o),
        .err_wlast_o     (err_wlast_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic e, input logic [2:0] b);
        ID_i      = route_pack(e, b);
        push_ID_i = 1'b1;
        tick();
        push_ID_i = 1'b0;
    endtask

    // Any routed beat must target at most one master.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            vectors++;
            assert ($onehot0(wvalid_o)) else begin
                miscompares++;
                $error("FAIL onehot_wvalid: observed %0h expected at most one bit", wvalid_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        test_en_i = 1'b0;
        wdata_i   = '0;
        wstrb_i   = '0;
        wlast_i   = 1'b0;
        wuser_i   = '0;
        wvalid_i  = 1'b0;
        wready_i  = '0;
        push_ID_i = 1'b0;
        ID_i      = '0;

        #12;
        chk("rst_wvalid", wvalid_o, 0);
        chk("rst_wready", wready_o, 0);
        chk("rst_err_wlast", err_wlast_o, 0);
        chk("rst_grant", grant_FIFO_ID_o, 1);
        chk("rst_state", dut.state_q, IDLE);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-beat write to port 2
        push(1'b0, 3'd2);
        wvalid_i = 1'b1; wlast_i = 1'b1; wdata_i = 64'hA1A1_0000_0000_0001;
        wstrb_i = 8'h3C; wuser_i = 6'h2A; wready_i = 8'h04;
        #1;
        chk("t1_wvalid", wvalid_o, 8'h04);
        chk("t1_wready", wready_o, 1);
        chk("t1_wdata", wdata_o[2], 64'hA1A1_0000_0000_0001);
        chk("t1_wstrb", wstrb_o[2], 8'h3C);
        chk("t1_wuser", wuser_o[2], 6'h2A);
        chk("t1_wlast", wlast_o[2], 1);
        chk("t1_err_wlast", err_wlast_o, 0);
        tick();
        #1;
        chk("t1_state", dut.state_q, IDLE);
        chk("t1_popped", wready_o, 0);
        wvalid_i = 1'b0; wlast_i = 1'b0;
        tick();

        // 4-beat burst to port 5, wready_i[5] toggling (stalled on even cycles)
        push(1'b0, 3'd5);
        begin
            int beat = 0;
            int cyc  = 0;
            while (beat < 4 && cyc < 20) begin
                wvalid_i = 1'b1;
                wdata_i  = 64'hB000 + 64'(beat);
                wlast_i  = (beat == 3);
                wready_i = (cyc % 2 == 0) ? 8'h00 : 8'h20;
                #1;
                chk("t2_wvalid", wvalid_o, 8'h20);
                chk("t2_wdata", wdata_o[5], 64'hB000 + 64'(beat));
                chk("t2_wready", wready_o, (cyc % 2 == 1));
                tick();
                if (cyc % 2 == 1) begin
                    beat++;
                    if (beat < 4) chk("t2_state_burst", dut.state_q, BURST);
                end
                cyc++;
            end
            chk("t2_beats", beat, 4);
            chk("t2_state_end", dut.state_q, IDLE);
            wlast_i = 1'b0;
            #1;
            chk("t2_popped", wready_o, 0);
            wvalid_i = 1'b0;
        end
        tick();

        // Decode-error burst of 3 beats
        push(1'b1, 3'd0);
        wready_i = 8'h00;
        for (int b = 0; b < 3; b++) begin
            wvalid_i = 1'b1;
            wlast_i  = (b == 2);
            wdata_i  = 64'hE000 + 64'(b);
            #1;
            chk("t3_wready", wready_o, 1);
            chk("t3_wvalid", wvalid_o, 0);
            chk("t3_err_wlast", err_wlast_o, (b == 2));
            tick();
            if (b == 0) chk("t3_state_drop", dut.state_q, DROP);
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
        #1;
        chk("t3_err_wlast_after", err_wlast_o, 0);
        chk("t3_state_end", dut.state_q, IDLE);
        tick();

        // Back-to-back 2-beat bursts to ports 1, 7, 1
        push(1'b0, 3'd1);
        push(1'b0, 3'd7);
        push(1'b0, 3'd1);
        wready_i = 8'hFF;
        for (int b = 0; b < 6; b++) begin
            int p;
            p = ports4[b / 2];
            wvalid_i = 1'b1;
            wlast_i  = (b % 2 == 1);
            wdata_i  = 64'hC000 + 64'(b);
            #1;
            chk("t4_wvalid", wvalid_o, 8'h01 << p);
            chk("t4_wready", wready_o, 1);
            chk("t4_wdata", wdata_o[p], 64'hC000 + 64'(b));
            tick();
        end
        wlast_i = 1'b0;
        #1;
        chk("t4_empty", wready_o, 0);
        wvalid_i = 1'b0;
        tick();

        // Fill the FIFO; a push coinciding with the first pop while full is dropped
        for (int i = 0; i < 8; i++) begin
            chk("t5_grant_pre", grant_FIFO_ID_o, 1);
            push(1'b0, 3'(i));
        end
        #1;
        chk("t5_grant_full", grant_FIFO_ID_o, 0);
        wready_i = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            wvalid_i = 1'b1;
            wlast_i  = 1'b1;
            wdata_i  = 64'hF000 + 64'(i);
            if (i == 0) begin
                ID_i      = route_pack(1'b0, 3'd3);
                push_ID_i = 1'b1;
            end
            #1;
            if (i == 0) chk("t5_grant_on_pop", grant_FIFO_ID_o, 0);
            chk("t5_wvalid", wvalid_o, 8'h01 << i);
            chk("t5_wdata", wdata_o[i], 64'hF000 + 64'(i));
            tick();
            push_ID_i = 1'b0;
        end
        #1;
        chk("t5_extra_ignored", wready_o, 0);
        chk("t5_grant_after", grant_FIFO_ID_o, 1);
        wvalid_i = 1'b0; wlast_i = 1'b0;
        tick();

        // W beat waiting 3 cycles before its route is pushed
        wvalid_i = 1'b1; wlast_i = 1'b1; wdata_i = 64'hD0D0; wready_i = 8'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_wait_wready", wready_o, 0);
            chk("t6_wait_wvalid", wvalid_o, 0);
            tick();
        end
        ID_i      = route_pack(1'b0, 3'd6);
        push_ID_i = 1'b1;
        #1;
        chk("t6_push_cycle_wready", wready_o, 0);
        tick();
        push_ID_i = 1'b0;
        #1;
        chk("t6_wready", wready_o, 1);
        chk("t6_wvalid", wvalid_o, 8'h40);
        chk("t6_wdata", wdata_o[6], 64'hD0D0);
        tick();
        wvalid_i = 1'b0; wlast_i = 1'b0;
        tick();

        // Reset in the middle of a burst
        push(1'b0, 3'd3);
        wready_i = 8'h08; wvalid_i = 1'b1; wlast_i = 1'b0;
        tick();
        chk("t7_state_burst", dut.state_q, BURST);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_state", dut.state_q, IDLE);
        chk("t7_rst_wvalid", wvalid_o, 0);
        chk("t7_rst_wready", wready_o, 0);
        chk("t7_rst_grant", grant_FIFO_ID_o, 1);
        wvalid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
